// File: rtl/jtag_dbg_pkg.sv
// Shared definitions for the JTAGG user-chain debug logic (TX and RX sides).
package jtag_dbg_pkg;

    localparam int DBG_WIDTH = 32;

    localparam logic CHAIN_ER1 = 1'b0;
    localparam logic CHAIN_ER2 = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tap_state_t;

endpackage

// File: rtl/jtck_edge.sv
// Oversamples the asynchronous JTCK into clk and emits one-clock rise/fall pulses.
// Edge-to-pulse latency is SYNC-1 clocks; reload preloads the history so no false edge appears.
module jtck_edge #(
    parameter int SYNC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic jtck,
    input  logic reload,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] tck_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sh <= '0;
        end else if (reload) begin
            tck_sh <= {SYNC{jtck}};
        end else begin
            tck_sh <= {tck_sh[SYNC-2:0], jtck};
        end
    end

    assign rise = !tck_sh[SYNC-1] &&  tck_sh[SYNC-2];
    assign fall =  tck_sh[SYNC-1] && !tck_sh[SYNC-2];

endmodule

// File: rtl/jtag_dr_tx.sv
// JTAG DR transmitter: a one-entry holding register is loaded into the DR on Capture-DR of
// its chain and shifted out LSB-first on JTDO1/JTDO2; TDO changes on falling TCK.
module jtag_dr_tx
    import jtag_dbg_pkg::*;
#(
    parameter int WIDTH = DBG_WIDTH,
    parameter int SYNC  = 4
) (
    input  logic             clk48m,
    input  logic             rst,
    input  logic             jtck,
    input  logic             jshift,
    input  logic             jce1,
    input  logic             jce2,
    input  logic             jrstn,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_sel,
    input  logic             tx_wr,
    output logic             tx_full,
    output logic             tx_done,
    output logic             tx_overrun,
    output logic             jtdo1,
    output logic             jtdo2
);

    tap_state_t       state, state_nxt;
    logic [WIDTH-1:0] hold;
    logic             hold_sel;
    logic [WIDTH-1:0] sr;
    logic             tdo_q;
    logic             act_sel;
    logic             rise, fall;
    logic             cap, cap_sel, take, shift_en;

    jtck_edge #(.SYNC(SYNC)) u_edge (
        .clk    (clk48m),
        .rst    (rst),
        .jtck   (jtck),
        .reload (!jrstn),
        .rise   (rise),
        .fall   (fall)
    );

    assign cap      = jrstn && rise && !jshift && (jce1 || jce2);
    assign cap_sel  = jce2 ? CHAIN_ER2 : CHAIN_ER1;
    assign take     = cap && tx_full && (hold_sel == cap_sel);
    assign shift_en = jrstn && rise && (state == SHIFT) && jshift &&
                      (act_sel ? jce2 : jce1);

    always_comb begin
        state_nxt = state;
        if (!jrstn) begin
            state_nxt = IDLE;
        end else if (rise) begin
            if (cap) begin
                state_nxt = SHIFT;
            end else if (state == SHIFT && !jce1 && !jce2) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk48m) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A capture in the same clock as a write consumes the old word before the new one lands.
    always_ff @(posedge clk48m) begin
        if (rst) begin
            hold       <= '0;
            hold_sel   <= 1'b0;
            tx_full    <= 1'b0;
            tx_done    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            tx_done    <= take;
            tx_overrun <= tx_wr && tx_full && !take;
            if (tx_wr) begin
                hold     <= tx_data;
                hold_sel <= tx_sel;
                tx_full  <= 1'b1;
            end else if (take) begin
                tx_full  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk48m) begin
        if (rst || !jrstn) begin
            sr      <= '0;
            tdo_q   <= 1'b0;
            act_sel <= 1'b0;
        end else if (rise) begin
            if (cap) begin
                act_sel <= cap_sel;
                sr      <= take ? hold : '0;
            end else if (shift_en) begin
                sr      <= {1'b0, sr[WIDTH-1:1]};
            end
        end else if (fall) begin
            tdo_q <= sr[0];
        end
    end

    assign jtdo1 = (state == SHIFT) && tdo_q && !act_sel;
    assign jtdo2 = (state == SHIFT) && tdo_q &&  act_sel;

endmodule

// File: tb/tb_jtag_dr_tx.sv
// Bench for jtag_dr_tx: directed vector table, hand-written corner sequences, random scans
// checked against a transaction-level model of the holding register and chain selection.
module tb_jtag_dr_tx;

    localparam int HALF = 6;

    logic        clk48m = 1'b0;
    logic        rst = 1'b1;
    logic        jtck = 1'b0, jshift = 1'b0, jce1 = 1'b0, jce2 = 1'b0, jrstn = 1'b1;
    logic [31:0] tx_data = '0;
    logic        tx_sel = 1'b0, tx_wr = 1'b0;
    logic        tx_full, tx_done, tx_overrun, jtdo1, jtdo2;

    jtag_dr_tx #(.WIDTH(32), .SYNC(4)) dut (
        .clk48m(clk48m), .rst(rst), .jtck(jtck), .jshift(jshift), .jce1(jce1), .jce2(jce2),
        .jrstn(jrstn), .tx_data(tx_data), .tx_sel(tx_sel), .tx_wr(tx_wr), .tx_full(tx_full),
        .tx_done(tx_done), .tx_overrun(tx_overrun), .jtdo1(jtdo1), .jtdo2(jtdo2)
    );

    always #5 clk48m = ~clk48m;

    int n_chk = 0, n_pass = 0;
    int done_cnt = 0, ovr_cnt = 0;

    // Transaction-level model: a single mailbox slot tagged with its chain.
    logic [31:0] m_hold = '0;
    logic        m_sel = 1'b0, m_full = 1'b0;
    int          m_done = 0, m_ovr = 0;

    always @(negedge clk48m) begin
        if (tx_done)    done_cnt++;
        if (tx_overrun) ovr_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk48m);
        #1;
    endtask

    function automatic void model_write(input logic [31:0] d, input logic s);
        if (m_full) m_ovr++;
        m_hold = d; m_sel = s; m_full = 1'b1;
    endfunction

    function automatic logic [31:0] model_capture(input logic c);
        logic [31:0] w;
        w = '0;
        if (m_full && m_sel == c) begin
            w = m_hold; m_full = 1'b0; m_done++;
        end
        return w;
    endfunction

    task automatic write(input logic [31:0] d, input logic s);
        tx_data = d; tx_sel = s; tx_wr = 1'b1;
        tick(1);
        tx_wr = 1'b0;
        model_write(d, s);
        tick(1);
    endtask

    // Capture-DR rise; optionally strobes tx_wr in the clock the rise is detected.
    task automatic capture(input logic c, input logic cw_en, input logic [31:0] cw_d,
                           input logic cw_s, output logic [31:0] word);
        jce1 = (c == 1'b0); jce2 = (c == 1'b1); jshift = 1'b0;
        jtck = 1'b1;
        word = model_capture(c);
        if (cw_en) begin
            tick(3);
            tx_data = cw_d; tx_sel = cw_s; tx_wr = 1'b1;
            tick(1);
            tx_wr = 1'b0;
            model_write(cw_d, cw_s);
            tick(HALF - 4);
        end else begin
            tick(HALF);
        end
        jtck = 1'b0; jshift = 1'b1;
        tick(HALF);
    endtask

    task automatic shift_bits(input int n, input logic c, output logic [63:0] got,
                              output logic other_hi);
        got = '0; other_hi = 1'b0;
        for (int i = 0; i < n; i++) begin
            got[i] = c ? jtdo2 : jtdo1;
            if ((c ? jtdo1 : jtdo2) !== 1'b0) other_hi = 1'b1;
            jtck = 1'b1;
            tick(HALF);
            jtck = 1'b0;
            tick(HALF);
        end
    endtask

    task automatic exit_scan();
        jce1 = 1'b0; jce2 = 1'b0; jshift = 1'b0;
        jtck = 1'b1; tick(HALF);
        jtck = 1'b0; tick(HALF);
    endtask

    task automatic scan(input logic c, input int n, input logic cw_en, input logic [31:0] cw_d,
                        input logic cw_s, output logic [63:0] got, output logic [63:0] exp,
                        output logic other_hi);
        logic [31:0] w;
        capture(c, cw_en, cw_d, cw_s, w);
        shift_bits(n, c, got, other_hi);
        exit_scan();
        exp = {32'd0, w};
        if (n < 64) exp = exp & ((64'd1 << n) - 64'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        wsel;
        logic        csel;
        int          n;
        logic [63:0] exp_bits;
        int          exp_done;
        logic        exp_full;
    } vec_t;

    vec_t        vecs[5];
    logic [63:0] got, exp;
    logic        other_hi;
    int          d0;

    initial begin
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32, 64'h0000_0000_A5A5_0001, 1, 1'b0};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32, 64'h0,                   0, 1'b1};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 32, 64'h0000_0000_DEAD_BEEF, 1, 1'b0};
        vecs[3] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 40, 64'h0000_0000_1234_5678, 1, 1'b0};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b1,  8, 64'h0,                   0, 1'b0};

        tick(3);
        check("reset tx_full", tx_full, 0);
        check("reset tx_done", tx_done, 0);
        check("reset tx_overrun", tx_overrun, 0);
        check("reset jtdo", {jtdo1, jtdo2}, 0);
        rst = 1'b0;
        tick(2);

        foreach (vecs[k]) begin
            if (vecs[k].wr) write(vecs[k].data, vecs[k].wsel);
            d0 = done_cnt;
            scan(vecs[k].csel, vecs[k].n, 1'b0, '0, 1'b0, got, exp, other_hi);
            check($sformatf("vec%0d data", k), got, vecs[k].exp_bits);
            check($sformatf("vec%0d other line", k), other_hi, 0);
            check($sformatf("vec%0d done", k), done_cnt - d0, vecs[k].exp_done);
            check($sformatf("vec%0d full", k), tx_full, vecs[k].exp_full);
        end
        check("no overrun so far", ovr_cnt, 0);

        // Overwrite while full: one overrun, newest word wins.
        tx_data = 32'h1; tx_sel = 1'b0; tx_wr = 1'b1; tick(1); tx_wr = 1'b0;
        model_write(32'h1, 1'b0);
        check("full 1 clk after wr", tx_full, 1);
        tx_data = 32'h2; tx_wr = 1'b1; tick(1); tx_wr = 1'b0;
        model_write(32'h2, 1'b0);
        check("overrun pulse", tx_overrun, 1);
        tick(1);
        check("overrun one cycle", tx_overrun, 0);
        check("overrun count", ovr_cnt, 1);
        scan(1'b0, 32, 1'b0, '0, 1'b0, got, exp, other_hi);
        check("overrun data", got, 64'h2);

        // Write coinciding with capture: old word goes out, new word stays held.
        write(32'h7, 1'b0);
        d0 = done_cnt;
        scan(1'b0, 32, 1'b1, 32'h3, 1'b0, got, exp, other_hi);
        check("same-clk data", got, 64'h7);
        check("same-clk done", done_cnt - d0, 1);
        check("same-clk full", tx_full, 1);
        check("same-clk no overrun", ovr_cnt, 1);
        scan(1'b0, 32, 1'b0, '0, 1'b0, got, exp, other_hi);
        check("same-clk new hold", got, 64'h3);

        // TAP reset mid-shift.
        write(32'hCAFE_F00D, 1'b0);
        begin
            logic [31:0] w;
            capture(1'b0, 1'b0, '0, 1'b0, w);
        end
        shift_bits(10, 1'b0, got, other_hi);
        check("pre-jrstn bits", got[9:0], 64'h00D);
        jrstn = 1'b0; tick(2);
        check("jrstn jtdo", {jtdo1, jtdo2}, 0);
        check("jrstn full kept", tx_full, 0);
        jrstn = 1'b1; tick(2);
        shift_bits(4, 1'b0, got, other_hi);
        check("jrstn idle no shift", got, 0);
        exit_scan();
        write(32'h0BAD_CAFE, 1'b1);
        scan(1'b1, 32, 1'b0, '0, 1'b0, got, exp, other_hi);
        check("post-jrstn data", got, 64'h0BAD_CAFE);

        // System reset mid-shift also drops a pending word.
        write(32'hFFFF_FFFF, 1'b1);
        begin
            logic [31:0] w;
            capture(1'b1, 1'b0, '0, 1'b0, w);
        end
        shift_bits(10, 1'b1, got, other_hi);
        write(32'h5555_AAAA, 1'b0);
        rst = 1'b1; tick(1);
        check("rst outputs", {jtdo1, jtdo2, tx_full, tx_done, tx_overrun}, 0);
        rst = 1'b0;
        m_full = 1'b0; m_hold = '0; m_sel = 1'b0;
        tick(1);
        shift_bits(32, 1'b1, got, other_hi);
        check("post-rst zeros", {got[62:0], other_hi}, 0);
        exit_scan();
        scan(1'b0, 32, 1'b0, '0, 1'b0, got, exp, other_hi);
        check("rst cleared hold", got, 0);
        done_cnt = m_done; ovr_cnt = m_ovr;

        // Random traffic against the model.
        for (int it = 0; it < 30; it++) begin
            logic c, cw;
            int   n;
            if ($urandom_range(3, 0) != 0) write($urandom, 1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) write($urandom, 1'($urandom_range(1, 0)));
            c  = 1'($urandom_range(1, 0));
            cw = ($urandom_range(5, 0) == 0);
            n  = $urandom_range(40, 1);
            scan(c, n, cw, $urandom, 1'($urandom_range(1, 0)), got, exp, other_hi);
            check($sformatf("rand%0d data", it), got, exp);
            check($sformatf("rand%0d other line", it), other_hi, 0);
            check($sformatf("rand%0d done", it), done_cnt, m_done);
            check($sformatf("rand%0d overrun", it), ovr_cnt, m_ovr);
            check($sformatf("rand%0d full", it), tx_full, m_full);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
